// File: rtl/boron_round_engine.sv
// boron_round_engine: iterative BORON-80 block encryption, one round per clock.
// Holds the 64-bit state, the 80-bit key schedule and the 5-bit round counter.
// A start/done handshake connects it to the surrounding core.

// Round-permutation stage: each 16-bit word is rotated left independently.
// Rotations are w0 by 1, w1 by 4, w2 by 7 and w3 by 9.
module boron_perm (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  assign dout = {din[54:48], din[63:55],   // w3 <<< 9
                 din[40:32], din[47:41],   // w2 <<< 7
                 din[27:16], din[31:28],   // w1 <<< 4
                 din[14:0],  din[15]};     // w0 <<< 1
endmodule

module boron_round_engine #(
  parameter int ROUNDS = 25   // legal 1..31, the round constant is 5 bits wide
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [63:0] pt_i,
  input  logic [79:0] key_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] ct_o
);

  localparam logic [4:0] LAST_RC = 5'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] s_q;
  logic [79:0] k_q;
  logic [4:0]  rc_q;
  logic [63:0] ct_q;
  logic        busy_q, done_q;

  logic        load, step, finish;
  logic [63:0] x, y, z, s_next;
  logic [79:0] k_rot, k_next;

  function automatic logic [3:0] sbox(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h0: r = 4'hE;  4'h1: r = 4'h4;  4'h2: r = 4'hB;  4'h3: r = 4'h1;
      4'h4: r = 4'h7;  4'h5: r = 4'h9;  4'h6: r = 4'hC;  4'h7: r = 4'hA;
      4'h8: r = 4'hD;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'hF;
      4'hC: r = 4'h8;  4'hD: r = 4'h5;  4'hE: r = 4'h3;  default: r = 4'h6;
    endcase
    return r;
  endfunction

  // Round function: add round key, then the 16-wide S-box layer.
  always_comb begin
    x = s_q ^ k_q[63:0];
    y = '0;
    for (int i = 0; i < 16; i++) begin
      y[4*i +: 4] = sbox(x[4*i +: 4]);
    end
  end

  boron_perm u_perm (
    .din  (y),
    .dout (z)
  );

  // Word XOR layer: o0=w0^w2, o1=w1^w3, o2=w2, o3=w3^w0.
  assign s_next = {z[63:48] ^ z[15:0],
                   z[47:32],
                   z[31:16] ^ z[63:48],
                   z[15:0]  ^ z[47:32]};

  // Key schedule runs alongside the round: rotate, S-box low nibble, add rc.
  always_comb begin
    k_rot          = {k_q[66:0], k_q[79:67]};
    k_next         = k_rot;
    k_next[3:0]    = sbox(k_rot[3:0]);
    k_next[63:59]  = k_rot[63:59] ^ rc_q;
  end

  // Next-state and control decode; unknown encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (rc_q == LAST_RC) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, key, counter and output registers; reset clears everything.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      k_q     <= '0;
      rc_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= finish;
      if (load) begin
        s_q  <= pt_i;
        k_q  <= key_i;
        rc_q <= 5'd1;
      end else if (step) begin
        s_q  <= s_next;
        k_q  <= k_next;
        rc_q <= rc_q + 5'd1;
      end
      if (finish) begin
        ct_q <= s_next ^ k_next[63:0];
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ct_o   = ct_q;

endmodule

// File: tb/tb_boron_round_engine.sv
// Bench for boron_round_engine: a one-round instance and a 25-round instance
// driven with random blocks and compared against a word-level cipher model.
module tb_boron_round_engine;

  localparam int R25 = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start25;
  logic [63:0] pt1, pt25;
  logic [79:0] key1, key25;
  logic        busy1, done1, busy25, done25;
  logic [63:0] ct1, ct25;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [3:0] SBOX [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                       4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

  always #5 clk = ~clk;

  boron_round_engine #(.ROUNDS(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .pt_i(pt1), .key_i(key1),
    .busy_o(busy1), .done_o(done1), .ct_o(ct1));

  boron_round_engine #(.ROUNDS(R25)) u_dut25 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start25), .pt_i(pt25), .key_i(key25),
    .busy_o(busy25), .done_o(done25), .ct_o(ct25));

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int a);
    return (v << a) | (v >> (16 - a));
  endfunction

  // Reference cipher written from the algorithm description.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] key,
                                              input int rounds);
    logic [63:0] st;
    logic [79:0] k;
    logic [15:0] w [4];
    int          rots [4];
    rots = '{1, 4, 7, 9};
    st = pt;
    k  = key;
    for (int r = 1; r <= rounds; r++) begin
      st = st ^ k[63:0];
      for (int n = 0; n < 16; n++) st[4*n +: 4] = SBOX[st[4*n +: 4]];
      for (int i = 0; i < 4; i++) w[i] = rotl16(st[16*i +: 16], rots[i]);
      st = {w[3] ^ w[0], w[2], w[1] ^ w[3], w[0] ^ w[2]};
      k = {k[66:0], k[79:67]};
      k[3:0] = SBOX[k[3:0]];
      k[63:59] = k[63:59] ^ 5'(r);
    end
    return st ^ k[63:0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [79:0] rnd80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 25-round block with full latency accounting; optional starts while busy.
  task automatic run_block(input logic [63:0] pt, input logic [79:0] key, input bit interfere);
    int          busy_cnt, done_cnt, done_at, both;
    logic [63:0] ct_at, exp;
    exp = ref_encrypt(pt, key, R25);
    busy_cnt = 0; done_cnt = 0; done_at = -1; both = 0; ct_at = '0;
    pt25 = pt; key25 = key; start25 = 1'b1;
    tick();
    start25 = 1'b0;
    for (int c = 0; c <= R25 + 3; c++) begin
      if (busy25) busy_cnt++;
      if (done25) begin
        done_cnt++;
        done_at = c;
        ct_at = ct25;
      end
      if (busy25 && done25) both++;
      if (interfere && (c == 3 || c == 10)) begin
        start25 = 1'b1;
        pt25 = rnd64();
        key25 = rnd80();
      end else begin
        start25 = 1'b0;
      end
      tick();
    end
    start25 = 1'b0;
    chk("busy_cycles", 80'(busy_cnt), 80'(R25));
    chk("done_pulses", 80'(done_cnt), 80'd1);
    chk("done_latency", 80'(done_at), 80'(R25));
    chk("ct_block", {16'h0, ct_at}, {16'h0, exp});
    chk("busy_done_excl", 80'(both), 80'd0);
    chk("ct_hold", {16'h0, ct25}, {16'h0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] p;
    logic [79:0] k;
    rst_n = 1'b0;
    start1 = 1'b1; start25 = 1'b1;
    pt1 = rnd64(); key1 = rnd80(); pt25 = rnd64(); key25 = rnd80();

    // Reset held with start asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy1", 80'(busy1), 80'd0);
      chk("rst_done1", 80'(done1), 80'd0);
      chk("rst_ct1", {16'h0, ct1}, 80'd0);
      chk("rst_busy25", 80'(busy25), 80'd0);
      chk("rst_done25", 80'(done25), 80'd0);
      chk("rst_ct25", {16'h0, ct25}, 80'd0);
    end
    start1 = 1'b0; start25 = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single round, all-zero vector.
    pt1 = '0; key1 = '0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("r1_busy", 80'(busy1), 80'd1);
    chk("r1_done_early", 80'(done1), 80'd0);
    tick();
    chk("r1_done", 80'(done1), 80'd1);
    chk("r1_busy_off", 80'(busy1), 80'd0);
    chk("r1_ct_known", {16'h0, ct1}, {16'h0, 64'h0800_7777_3333_AAA4});
    chk("r1_ct_model", {16'h0, ct1}, {16'h0, ref_encrypt(64'h0, 80'h0, 1)});
    tick();
    chk("r1_done_pulse", 80'(done1), 80'd0);
    chk("r1_ct_hold", {16'h0, ct1}, {16'h0, 64'h0800_7777_3333_AAA4});

    // Random single-round blocks.
    for (int i = 0; i < 6; i++) begin
      p = rnd64(); k = rnd80();
      pt1 = p; key1 = k; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      chk("r1_rand_done", 80'(done1), 80'd1);
      chk("r1_rand_ct", {16'h0, ct1}, {16'h0, ref_encrypt(p, k, 1)});
    end

    // Full-latency random blocks.
    for (int i = 0; i < 3; i++) run_block(rnd64(), rnd80(), 1'b0);

    // Starts while busy are ignored.
    run_block(rnd64(), rnd80(), 1'b1);

    // Back-to-back with start held high for 60 cycles.
    begin
      logic [63:0] exp_q [$];
      int          due_q [$];
      int          next_free;
      bit          exp_done;
      next_free = 0;
      for (int t = 0; t < 90; t++) begin
        p = rnd64(); k = rnd80();
        pt25 = p; key25 = k; start25 = (t < 60);
        if (t < 60 && t >= next_free) begin
          exp_q.push_back(ref_encrypt(p, k, R25));
          due_q.push_back(t + R25);
          next_free = t + R25 + 1;
        end
        tick();
        exp_done = (due_q.size() > 0) && (due_q[0] == t);
        chk("b2b_done", 80'(done25), 80'(exp_done));
        if (exp_done) begin
          chk("b2b_ct", {16'h0, ct25}, {16'h0, exp_q[0]});
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
      start25 = 1'b0;
      chk("b2b_all_done", 80'(due_q.size()), 80'd0);
    end
    tick();

    // Reset in the middle of a run.
    begin
      int done_cnt;
      done_cnt = 0;
      pt25 = rnd64(); key25 = rnd80(); start25 = 1'b1;
      tick();
      start25 = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (done25) done_cnt++;
        rst_n = (c != 11);
        tick();
        if (c == 11) begin
          chk("mid_rst_busy", 80'(busy25), 80'd0);
          chk("mid_rst_ct", {16'h0, ct25}, 80'd0);
        end
      end
      rst_n = 1'b1;
      chk("mid_rst_no_done", 80'(done_cnt), 80'd0);
      chk("mid_rst_idle", 80'(busy25), 80'd0);
      chk("mid_rst_ct_zero", {16'h0, ct25}, 80'd0);
    end
    run_block(rnd64(), rnd80(), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boron_round_engine.md
# boron_round_engine

Iterative BORON-80 encryption engine built around the existing 64-bit round-permutation stage (per-word rotations of 1, 4, 7 and 9 bits). Each clock it runs one round: add round key, S-box layer, round permutation, then the word-level XOR layer that consumes the permutation output. It also holds the state register, the 80-bit key schedule and the round counter, and exposes a start/done handshake to the surrounding core.

## Interface
- ROUNDS, 25: number of full rounds; legal range 1..31, since the round constant is 5 bits.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- start_i  input  1  pulse or level; sampled only in IDLE.
- pt_i  input  64  plaintext, captured with start_i.
- key_i  input  80  master key, captured with start_i.
- busy_o  output  1  high while rounds are executing.
- done_o  output  1  one-cycle pulse when ct_o becomes valid.
- ct_o  output  64  ciphertext; held until the next accepted start_i.

## Operation
- **Datapath per round**, with state S, key register K and rk = K[63:0]:
  - x = S ^ rk.
  - y = 16 parallel 4-bit S-boxes on x. S = {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6}, with nibble 0 at x[3:0].
  - z = round permutation of y, using an instance of the existing stage. Words w0 = z[15:0] .. w3 = z[63:48].
  - XOR layer: o0 = w0^w2, o1 = w1^w3, o2 = w2, o3 = w3^w0. S_next = {o3,o2,o1,o0}.
- **Key update**, same cycle as the round, with round constant rc = current round number, 5 bits, starting at 1:
  - K = K <<< 13 (80-bit rotate left).
  - K[3:0] = S(K[3:0]).
  - K[63:59] ^= rc.
- **Output whitening:** ct = S ^ K[63:0], taken after the last round's state and key updates.
- **FSM states:**
  - IDLE: busy_o=0. On start_i, load S=pt_i, K=key_i, rc=1, then go to RUN.
  - RUN: one round per cycle. When rc==ROUNDS, register ct_o = S_next ^ K_next[63:0], pulse done_o and go to IDLE. Otherwise rc++.
- **Invalid state encoding** returns to IDLE.
- **start_i while in RUN** is ignored, with no restart and no queuing.
- **start_i in the cycle done_o is high:** the FSM is already in IDLE and the start is accepted. busy_o rises next cycle and ct_o keeps its old value until overwritten at the next done.

## Timing
- **Reset** (rst_ni low at an edge): state=IDLE, busy_o=0, done_o=0, ct_o=0, S=0, K=0, rc=0. Reset wins over start_i in the same cycle.
- **Reset mid-operation** aborts the operation. No done_o is produced and ct_o is cleared to 0.
- **Latency:** start_i sampled at edge N gives busy_o=1 from N through N+ROUNDS. done_o=1 and ct_o valid after edge N+ROUNDS. busy_o=0 after edge N+ROUNDS.
- **Throughput:** one block per ROUNDS+1 cycles, with back-to-back start_i held high.
- **busy_o and done_o** are registered and never high together.
- **Critical path** is one round: XOR → S-box → wires → XOR. The key schedule runs in parallel.

## Test plan
- **Reset values:** hold rst_ni=0 for 3 cycles with start_i=1 → busy_o=0, done_o=0, ct_o=0 throughout.
- **Single round:** ROUNDS=1, pt=0, key=0, pulse start → done_o one cycle later, ct_o=0x0800_7777_3333_AAA4.
- **Full latency:** ROUNDS=25, random pt/key → busy_o high for exactly 25 cycles, done_o pulses exactly once after the 25th, and ct_o matches the reference model.
- **Start while busy:** pulse start_i with new pt at cycles 3 and 10 of RUN → the original block completes on schedule and ct_o reflects the first pt only.
- **Back-to-back:** start_i held high for 60 cycles with ROUNDS=25 → done_o pulses every 26 cycles, and each ct_o matches the model for pt_i sampled at the corresponding accept.
- **Reset mid-run:** deassert rst_ni at round 12 for 1 cycle → no done_o, ct_o=0, FSM in IDLE. The next start produces a correct ciphertext.
